// File: rtl/stim_scheduler.sv
// Frame scheduler for a four-channel biphasic pulse generator: holds per-channel
// pulse settings, fires each enabled channel in turn and polices frame period and pulse timeout.
module stim_scheduler #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 1200,
  parameter int TO_W    = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [9:0] period,
  input  logic [3:0] gap,
  input  logic       cfg_we,
  input  logic [1:0] cfg_ch,
  input  logic       cfg_en,
  input  logic [8:0] cfg_ktp,
  input  logic [5:0] cfg_sktp,
  input  logic [6:0] cfg_ipd,
  input  logic [8:0] cfg_adp,
  input  logic [5:0] cfg_sadp,
  input  logic       done_f,
  output logic       start_f,
  output logic [8:0] ktp,
  output logic [5:0] sktp,
  output logic [6:0] ipd,
  output logic [8:0] adp,
  output logic [5:0] sadp,
  output logic [3:0] elec_sel,
  output logic       busy,
  output logic       frame_tick,
  output logic       overrun,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_FRAME_START, S_SCAN, S_LOAD, S_FIRE, S_WAIT_DONE, S_GAP, S_FRAME_WAIT
  } state_t;

  typedef struct packed {
    logic [8:0] ktp;
    logic [5:0] sktp;
    logic [6:0] ipd;
    logic [8:0] adp;
    logic [5:0] sadp;
  } pulse_t;

  typedef struct packed {
    logic   en;
    pulse_t p;
  } chan_cfg_t;

  state_t            state_q, state_d;
  chan_cfg_t         shadow_q [NCH];
  chan_cfg_t         shadow_d [NCH];
  chan_cfg_t         active_q [NCH];
  chan_cfg_t         active_d [NCH];
  pulse_t            pulse_q, pulse_d;
  logic [3:0]        sel_q, sel_d;
  logic [1:0]        ch_q, ch_d;
  logic [9:0]        frame_cnt_q, frame_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic last_ch, ch_en, timeout_hit, in_work, frame_end;

  assign last_ch     = (ch_q == 2'(NCH - 1));
  assign ch_en       = active_q[ch_q].en;
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign in_work     = state_q inside {S_SCAN, S_LOAD, S_FIRE, S_WAIT_DONE, S_GAP};
  // frame_cnt holds the cycles left in the frame; the frame's last cycle is when it reads 1 or 0.
  assign frame_end   = (frame_cnt_q <= 10'd1);

  // Generator handshake: start_f is a single-cycle strobe issued in FIRE with the
  // parameters and elec_sel already stable; the generator answers with a single-cycle
  // done_f, which is only honoured in WAIT_DONE. Parameters are held until done_f.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (run && !timeout_q) state_d = S_FRAME_START;
      S_FRAME_START: state_d = S_SCAN;
      S_SCAN: begin
        if (!run)         state_d = S_IDLE;
        else if (ch_en)   state_d = S_LOAD;
        else if (last_ch) state_d = S_FRAME_WAIT;
      end
      S_LOAD:        state_d = S_FIRE;
      S_FIRE:        state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (done_f)           state_d = S_GAP;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          if (!run)         state_d = S_IDLE;
          else if (last_ch) state_d = S_FRAME_WAIT;
          else              state_d = S_SCAN;
        end
      end
      S_FRAME_WAIT: begin
        if (!run)           state_d = S_IDLE;
        else if (frame_end) state_d = S_FRAME_START;
      end
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_f    = (state_q == S_FIRE);
    frame_tick = (state_q == S_FRAME_START);
    busy       = (state_q != S_IDLE);
    state_dbg  = state_q;
  end

  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    pulse_d     = pulse_q;
    sel_d       = sel_q;
    ch_d        = ch_q;
    frame_cnt_d = frame_cnt_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;

    if (cfg_we) begin
      shadow_d[cfg_ch] = '{en: cfg_en,
                           p: '{ktp: cfg_ktp, sktp: cfg_sktp, ipd: cfg_ipd,
                                adp: cfg_adp, sadp: cfg_sadp}};
    end

    if (state_q != S_IDLE && frame_cnt_q != 10'd0) frame_cnt_d = frame_cnt_q - 10'd1;
    if (in_work && frame_cnt_q == 10'd0) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!run) begin
          overrun_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_FRAME_START: begin
        active_d    = shadow_q;
        frame_cnt_d = (period == 10'd0) ? 10'd0 : period - 10'd1;
        ch_d        = 2'd0;
      end
      S_SCAN: if (run && !ch_en && !last_ch) ch_d = ch_q + 2'd1;
      S_LOAD: begin
        pulse_d = active_q[ch_q].p;
        sel_d   = 4'b0001 << ch_q;
      end
      S_FIRE: to_cnt_d = '0;
      S_WAIT_DONE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (done_f) begin
          sel_d     = 4'b0000;
          gap_cnt_d = gap;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          pulse_d   = '0;
          sel_d     = 4'b0000;
        end
      end
      S_GAP: begin
        if (gap_cnt_q != 4'd0)         gap_cnt_d = gap_cnt_q - 4'd1;
        else if (run && !last_ch)      ch_d      = ch_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q    <= '{default: '0};
      active_q    <= '{default: '0};
      pulse_q     <= '0;
      sel_q       <= '0;
      ch_q        <= '0;
      frame_cnt_q <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pulse_q     <= pulse_d;
      sel_q       <= sel_d;
      ch_q        <= ch_d;
      frame_cnt_q <= frame_cnt_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ktp         = pulse_q.ktp;
  assign sktp        = pulse_q.sktp;
  assign ipd         = pulse_q.ipd;
  assign adp         = pulse_q.adp;
  assign sadp        = pulse_q.sadp;
  assign elec_sel    = sel_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule
